// File: rtl/dmem_resp_pkg.sv
// Shared types for the data-memory responder and the control unit that drives it.
// No logic here: state encodings, access-size encoding, alignment helper.
package dmem_resp_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } dmem_state_t;

    typedef enum logic {
        SZ_WORD  = 1'b0,
        SZ_DWORD = 1'b1
    } acc_size_t;

    typedef enum logic [2:0] {
        CU_FETCH     = 3'd0,
        CU_DECODE    = 3'd1,
        CU_EXECUTE   = 3'd2,
        CU_MEM       = 3'd3,
        CU_WRITEBACK = 3'd4
    } cu_state_t;

    function automatic logic misaligned(input acc_size_t sz, input logic [2:0] lsb);
        return (sz == SZ_DWORD) ? (lsb != 3'd0) : (lsb[1:0] != 2'd0);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Doubleword storage with word write-merge and size-formatted combinational read.
// Latency: write commits on the clock edge; read is same-cycle. No backpressure.
module dmem_array
    import dmem_resp_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             we_i,
    input  acc_size_t        size_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic             hi_i,
    input  logic [63:0]      wdata_i,
    output logic [63:0]      rdata_o
);

    logic [63:0] mem_q [DEPTH];
    logic [63:0] entry;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 64'd0;
            end
        end else if (we_i) begin
            if (size_i == SZ_DWORD) begin
                mem_q[idx_i] <= wdata_i;
            end else if (hi_i) begin
                mem_q[idx_i][63:32] <= wdata_i[31:0];
            end else begin
                mem_q[idx_i][31:0] <= wdata_i[31:0];
            end
        end
    end

    assign entry = mem_q[idx_i];

    always_comb begin
        rdata_o = entry;
        if (size_i == SZ_WORD) begin
            rdata_o = hi_i ? {32'd0, entry[63:32]} : {32'd0, entry[31:0]};
        end
    end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: accepts one request in IDLE, waits WAIT_CYCLES, then responds.
// Latency: WAIT_CYCLES+1 cycles from acceptance edge to RESP_VALID.
// Backpressure: response held stable until RESP_READY; REQ_READY only in IDLE.
module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int          DEPTH       = 32
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        DMEM_RW,
    input  logic        MEM64,
    input  logic [63:0] ADDR,
    input  logic [63:0] WDATA,
    output logic        RESP_VALID,
    input  logic        RESP_READY,
    output logic [63:0] RDATA,
    output logic        ERR
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    dmem_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rw_q, rw_d;
    logic        mem64_q, mem64_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        enter_resp;
    logic        cur_rw;
    acc_size_t   cur_size;
    logic [63:0] cur_addr;
    logic [63:0] cur_wdata;
    logic        cur_err;
    logic [63:0] arr_rdata;

    // With zero wait states the commit edge is the acceptance edge, so decode the live inputs.
    assign cur_rw    = (state_q == S_IDLE) ? DMEM_RW : rw_q;
    assign cur_size  = acc_size_t'((state_q == S_IDLE) ? MEM64 : mem64_q);
    assign cur_addr  = (state_q == S_IDLE) ? ADDR : addr_q;
    assign cur_wdata = (state_q == S_IDLE) ? WDATA : wdata_q;
    assign cur_err   = misaligned(cur_size, cur_addr[2:0]) | (|cur_addr[63:3+IDX_W]);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rw_d       = rw_q;
        mem64_d    = mem64_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        enter_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (REQ_VALID) begin
                    rw_d    = DMEM_RW;
                    mem64_d = MEM64;
                    addr_d  = ADDR;
                    wdata_d = WDATA;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (RESP_READY) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (enter_resp) begin
            rdata_d = (cur_rw || cur_err) ? 64'd0 : arr_rdata;
            err_d   = cur_err;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rw_q    <= 1'b0;
            mem64_q <= 1'b0;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            mem64_q <= mem64_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk_i   (CLK),
        .rst_n_i (RESET_N),
        .we_i    (enter_resp & cur_rw & ~cur_err),
        .size_i  (cur_size),
        .idx_i   (cur_addr[3+IDX_W-1:3]),
        .hi_i    (cur_addr[2]),
        .wdata_i (cur_wdata),
        .rdata_o (arr_rdata)
    );

    assign REQ_READY  = (state_q == S_IDLE);
    assign RESP_VALID = (state_q == S_RESP);
    assign RDATA      = rdata_q;
    assign ERR        = err_q;

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, wait states inserted between request acceptance and response (0..15).
REQ-002 Parameter DEPTH, default 32, number of 64-bit doubleword storage entries (power of two).
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RESET_N  input  1  asynchronous, active-low reset.
REQ-005 REQ_VALID  input  1  control unit presents a memory request.
REQ-006 REQ_READY  output  1  responder can accept a request this cycle.
REQ-007 DMEM_RW  input  1  0 = read, 1 = write; sampled on acceptance.
REQ-008 MEM64  input  1  1 = doubleword access, 0 = word access; sampled on acceptance.
REQ-009 ADDR  input  64  byte address; sampled on acceptance.
REQ-010 WDATA  input  64  write data; word writes use WDATA[31:0]; sampled on acceptance.
REQ-011 RESP_VALID  output  1  response available.
REQ-012 RESP_READY  input  1  control unit consumes the response.
REQ-013 RDATA  output  64  read data; zero for writes and errors.
REQ-014 ERR  output  1  request was misaligned or out of range; valid with RESP_VALID.

Function
REQ-015 Acceptance shall occur on a rising edge where REQ_VALID=1 and REQ_READY=1; all request fields shall be captured into internal registers at that edge.
REQ-016 The FSM shall have states IDLE, WAIT, RESP; REQ_READY shall be 1 only in IDLE.
REQ-017 IDLE -> WAIT on acceptance when WAIT_CYCLES>0; IDLE -> RESP directly when WAIT_CYCLES=0.
REQ-018 WAIT shall load a 4-bit counter with WAIT_CYCLES-1 on entry, decrement each cycle, and go to RESP after the cycle in which it reads 0.
REQ-019 RESP_VALID shall be 1 exactly in RESP; RESP -> IDLE on the edge where RESP_READY=1; RESP_VALID, RDATA, ERR shall hold stable while RESP_READY=0.
REQ-020 Latency from acceptance edge to first RESP_VALID=1 cycle shall be WAIT_CYCLES+1 cycles.
REQ-021 Index = ADDR[3+log2(DEPTH)-1:3]; out of range when any ADDR bit above that field is 1.
REQ-022 Misaligned when MEM64=1 and ADDR[2:0]!=0, or MEM64=0 and ADDR[1:0]!=0.
REQ-023 On ERR, no storage update shall occur and RDATA shall be 0.
REQ-024 Doubleword read: RDATA = entry[index]; word read: RDATA = zero-extended entry[index] half selected by ADDR[2] (0 = bits 31:0, 1 = bits 63:32).
REQ-025 Doubleword write replaces the entry; word write replaces only the half selected by ADDR[2] with WDATA[31:0].
REQ-026 Writes shall commit on the edge entering RESP; reads shall sample storage on that same edge into a response register.
REQ-027 A read immediately following a write to the same address shall return the written data.
REQ-028 REQ_VALID asserted outside IDLE shall be ignored (no capture, no side effect).

Reset
REQ-029 RESET_N=0 shall immediately force state IDLE, REQ_READY=1, RESP_VALID=0, RDATA=0, ERR=0, wait counter=0, captured request registers=0.
REQ-030 RESET_N=0 shall clear all storage entries to 0.
REQ-031 Reset asserted mid-request (WAIT or RESP) shall abandon the request; a pending write not yet committed shall not commit.

Structure
REQ-032 FSM state enum (IDLE, WAIT, RESP) and the access-size encoding shall live in the shared package alongside the control unit's state enum.
REQ-033 Storage array with word/doubleword write-merge shall be a sub-module dmem_array; FSM, counter and error decode stay in dmem_resp.

Verification
REQ-034 Write 64-bit 0x1122334455667788 to ADDR 0x10, then 64-bit read 0x10 -> RDATA=0x1122334455667788, ERR=0, RESP_VALID first high 3 cycles after each acceptance (WAIT_CYCLES=2).
REQ-035 Word write 0xDEADBEEF to 0x14 over the entry above, then word reads 0x10 and 0x14 -> 0x0000000055667788 and 0x00000000DEADBEEF.
REQ-036 64-bit read at 0x0C and word read at 0x02 -> ERR=1, RDATA=0; write to 0x100 (DEPTH=32) -> ERR=1, later read of 0x0 returns 0.
REQ-037 Hold RESP_READY=0 for 5 cycles in RESP while toggling REQ_VALID -> RESP_VALID/RDATA stable, REQ_READY=0, no extra request accepted.
REQ-038 Assert RESET_N=0 during WAIT of a write to 0x08 -> outputs at reset values asynchronously; subsequent read of 0x08 returns 0.
REQ-039 WAIT_CYCLES=0 build: back-to-back requests with RESP_READY tied 1 -> one response every 2 cycles, latency 1 cycle.
